// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-search stage.
// State encoding, printable-character bounds and bus widths.
package ksa_pkg;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 9;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LO_A  = 8'h61;
  localparam logic [7:0] CH_LO_Z  = 8'h7A;

  typedef enum logic [2:0] {
    KS_IDLE     = 3'd0,
    KS_WAIT_DEC = 3'd1,
    KS_ADDR     = 3'd2,
    KS_LAT      = 3'd3,
    KS_CHECK    = 3'd4,
    KS_NEXT     = 3'd5,
    KS_FOUND    = 3'd6,
    KS_FAIL     = 3'd7
  } ks_state_t;

endpackage

// File: rtl/key_search_if.sv
// Key-search control/data bundle between the search FSM and the
// upstream pipeline / decrypted-message memory.
interface key_search_if;
  import ksa_pkg::*;

  logic              start;
  logic              decrypt_done;
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_rddata;
  logic [KEY_W-1:0]  key;
  logic              restart;
  logic              busy;
  logic              found;
  logic              failed;

  modport master (
    input  start, decrypt_done, dm_rddata,
    output dm_addr, key, restart, busy, found, failed
  );

  modport slave (
    output start, decrypt_done, dm_rddata,
    input  dm_addr, key, restart, busy, found, failed
  );

endinterface

// File: rtl/key_search_char_validator.sv
// Combinational plaintext check: lowercase ASCII letter or space.
module char_validator
  import ksa_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid
);

  assign valid = (ch == CH_SPACE) || ((ch >= CH_LO_A) && (ch <= CH_LO_Z));

endmodule

// File: rtl/key_search.sv
// Brute-force RC4 key-search controller: restarts the upstream pipeline per key, scans DM.
// Build option KEY_SEARCH_EARLY_ABORT_EN rejects a key on its first invalid byte.
module key_search
  import ksa_pkg::*;
#(
  parameter int unsigned      MSG_LEN   = 32,
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF,
  parameter int unsigned      RD_LAT    = 2
) (
  input logic          clk,
  input logic          reset,
  key_search_if.master ks
);

  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  localparam logic [2:0] ST_IDLE     = KS_IDLE;
  localparam logic [2:0] ST_WAIT_DEC = KS_WAIT_DEC;
  localparam logic [2:0] ST_ADDR     = KS_ADDR;
  localparam logic [2:0] ST_LAT      = KS_LAT;
  localparam logic [2:0] ST_CHECK    = KS_CHECK;
  localparam logic [2:0] ST_NEXT     = KS_NEXT;
  localparam logic [2:0] ST_FOUND    = KS_FOUND;
  localparam logic [2:0] ST_FAIL     = KS_FAIL;

`ifdef KEY_SEARCH_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  logic [2:0]        state, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              restart_q, restart_d;
  logic              busy_q, busy_d;
  logic              found_q, found_d;
  logic              failed_q, failed_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [1:0]        wait_q, wait_d;
  logic              char_ok;
  logic              bad_now;

  char_validator u_char_validator (
    .ch    (ks.dm_rddata),
    .valid (char_ok)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    key_d     = key_q;
    addr_d    = addr_q;
    restart_d = 1'b0;
    busy_d    = busy_q;
    found_d   = found_q;
    failed_d  = failed_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    lat_d     = lat_q;
    wait_d    = wait_q;
    bad_now   = bad_q | ~char_ok;

    case (state)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (ks.start) begin
          key_d     = KEY_START;
          found_d   = 1'b0;
          failed_d  = 1'b0;
          busy_d    = 1'b1;
          restart_d = 1'b1;
          wait_d    = 2'd0;
          state_d   = ST_WAIT_DEC;
        end
      end
      // decrypt_done may still be stale from the previous key for two cycles
      ST_WAIT_DEC: begin
        if (wait_q != 2'd2) begin
          wait_d = wait_q + 2'd1;
        end else if (ks.decrypt_done) begin
          idx_d   = '0;
          bad_d   = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_d  = idx_q[ADDR_W-1:0];
        lat_d   = '0;
        state_d = (RD_LAT > 1) ? ST_LAT : ST_CHECK;
      end
      ST_LAT: begin
        if (lat_q == LAT_W'(RD_LAT - 2)) begin
          state_d = ST_CHECK;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_CHECK: begin
        bad_d = bad_now;
        if (EARLY_ABORT && !char_ok) begin
          state_d = ST_NEXT;
        end else if (idx_q == IDX_W'(MSG_LEN - 1)) begin
          if (bad_now) begin
            state_d = ST_NEXT;
          end else begin
            found_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FOUND;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ADDR;
        end
      end
      // Compare with >= so a KEY_START above KEY_MAX still terminates
      ST_NEXT: begin
        if (key_q >= KEY_MAX) begin
          key_d    = KEY_MAX;
          failed_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_FAIL;
        end else begin
          key_d     = key_q + KEY_W'(1);
          restart_d = 1'b1;
          wait_d    = 2'd0;
          state_d   = ST_WAIT_DEC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      key_q     <= '0;
      addr_q    <= '0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      found_q   <= 1'b0;
      failed_q  <= 1'b0;
      idx_q     <= '0;
      bad_q     <= 1'b0;
      lat_q     <= '0;
      wait_q    <= 2'd0;
    end else begin
      state     <= state_d;
      key_q     <= key_d;
      addr_q    <= addr_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      found_q   <= found_d;
      failed_q  <= failed_d;
      idx_q     <= idx_d;
      bad_q     <= bad_d;
      lat_q     <= lat_d;
      wait_q    <= wait_d;
    end
  end

  assign ks.dm_addr = addr_q;
  assign ks.key     = key_q;
  assign ks.restart = restart_q;
  assign ks.busy    = busy_q;
  assign ks.found   = found_q;
  assign ks.failed  = failed_q;

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: DM model with RD_LAT=2, MSG_LEN=4, two DUTs (normal / near-end key range).
`timescale 1ns/1ps
module tb_key_search;
  import ksa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_search_if bus0 ();
  key_search_if bus1 ();

  key_search #(.MSG_LEN(4), .KEY_START(24'h000000), .KEY_MAX(24'h3FFFFF), .RD_LAT(2)) u0 (
    .clk(clk), .reset(reset), .ks(bus0.master));
  key_search #(.MSG_LEN(4), .KEY_START(24'h3FFFFE), .KEY_MAX(24'h3FFFFF), .RD_LAT(2)) u1 (
    .clk(clk), .reset(reset), .ks(bus1.master));

`ifdef KEY_SEARCH_EARLY_ABORT_EN
  localparam int ABORT0_INTERVAL = 7;
`else
  localparam int ABORT0_INTERVAL = 16;
`endif

  // DM model: message chosen by key, one register stage (RD_LAT=2)
  logic [23:0] good_key0 = 24'd1;
  logic [31:0] good_msg0 = "abcd";
  logic [31:0] bad_msg0  = "ab#d";
  localparam logic [31:0] BAD_MSG1 = "ab#d";

  function automatic logic [7:0] msg_byte(input logic [31:0] m, input logic [7:0] a);
    logic [31:0] t;
    t = m << (8 * a[1:0]);
    return t[31:24];
  endfunction

  always @(posedge clk) begin
    bus0.dm_rddata <= msg_byte((bus0.key == good_key0) ? good_msg0 : bad_msg0, bus0.dm_addr);
    bus1.dm_rddata <= msg_byte(BAD_MSG1, bus1.dm_addr);
  end

  // Restart monitor
  int cyc = 0, rs0 = 0, rs1 = 0, last_rs_cyc = 0, rs_interval = 0, rs_wide = 0;
  logic prev_rs0 = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus0.restart) begin
      rs0         <= rs0 + 1;
      rs_interval <= cyc - last_rs_cyc;
      last_rs_cyc <= cyc;
    end
    if (bus0.restart && prev_rs0) rs_wide <= rs_wide + 1;
    prev_rs0 <= bus0.restart;
    if (bus1.restart) rs1 <= rs1 + 1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        found;
    logic        failed;
    logic [23:0] key;
    int          restarts;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] msg;
    logic [23:0] exp_key;
    int          exp_rs;
  } vec_t;

  task automatic pulse_start0();
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
  endtask

  task automatic wait_idle0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!bus0.busy && (bus0.found || bus0.failed)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic finish0(input int rs_before);
    exp_t e;
    bit ok;
    wait_idle0(ok);
    e = sbq.pop_front();
    check({e.name, " done"}, 32'(ok), 32'd1);
    check({e.name, " found"}, 32'(bus0.found), 32'(e.found));
    check({e.name, " failed"}, 32'(bus0.failed), 32'(e.failed));
    check({e.name, " key"}, 32'(bus0.key), 32'(e.key));
    check({e.name, " busy"}, 32'(bus0.busy), 32'd0);
    check({e.name, " restarts"}, 32'(rs0 - rs_before), 32'(e.restarts));
  endtask

  task automatic run0(input string name, input logic [23:0] gk, input logic [31:0] gm,
                      input logic [31:0] bm, input logic [23:0] ek, input int ers);
    int rs_before;
    good_key0 = gk; good_msg0 = gm; bad_msg0 = bm;
    sbq.push_back('{name, 1'b1, 1'b0, ek, ers});
    rs_before = rs0;
    pulse_start0();
    finish0(rs_before);
  endtask

  vec_t vecs[8];

  initial begin
    int   rs_before, rs_b1;
    bit   ok;
    reset = 1'b1;
    bus0.start = 1'b0; bus0.decrypt_done = 1'b1;
    bus1.start = 1'b0; bus1.decrypt_done = 1'b1;
    repeat (3) @(negedge clk);

    check("rst key", 32'(bus0.key), 32'd0);
    check("rst dm_addr", 32'(bus0.dm_addr), 32'd0);
    check("rst flags", {28'd0, bus0.restart, bus0.busy, bus0.found, bus0.failed}, 32'd0);
    check("rst state", 32'(u0.state), 32'(KS_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Key 3 is the only good one: restarts for keys 0..3
    run0("key3", 24'd3, "abcd", "ab#d", 24'd3, 4);
    rs_before = rs0;
    repeat (30) @(negedge clk);
    check("key3 no further restart", 32'(rs0 - rs_before), 32'd0);
    check("key3 found sticky", 32'(bus0.found), 32'd1);

    // Table: key 0 carries the test message, key 1 is always "abcd"
    vecs[0] = '{" z a", 24'd0, 1};
    vecs[1] = '{"abcd", 24'd0, 1};
    vecs[2] = '{"    ", 24'd0, 1};
    vecs[3] = '{"zzzz", 24'd0, 1};
    vecs[4] = '{"ab`d", 24'd1, 2};
    vecs[5] = '{"ab{d", 24'd1, 2};
    vecs[6] = '{"A bc", 24'd1, 2};
    vecs[7] = '{"abc!", 24'd1, 2};
    for (int v = 0; v < 8; v++) begin
      run0($sformatf("vec%0d", v), 24'd1, "abcd", vecs[v].msg, vecs[v].exp_key, vecs[v].exp_rs);
    end
    check("last-byte reject interval", 32'(rs_interval), 32'd16);

    // First byte bad; decrypt_done held high so stale-done is also exercised
    run0("abort0", 24'd1, "abcd", "#bcd", 24'd1, 2);
    check("abort0 interval", 32'(rs_interval), 32'(ABORT0_INTERVAL));

    // Key space exhaustion on the second DUT
    rs_b1 = rs1;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus1.busy && bus1.failed) begin ok = 1'b1; break; end
    end
    check("fail done", 32'(ok), 32'd1);
    check("fail failed", 32'(bus1.failed), 32'd1);
    check("fail found", 32'(bus1.found), 32'd0);
    check("fail key", 32'(bus1.key), 32'h3FFFFF);
    check("fail restarts", 32'(rs1 - rs_b1), 32'd2);

    // start while busy is ignored
    good_key0 = 24'd2; good_msg0 = "abcd"; bad_msg0 = "ab#d";
    sbq.push_back('{"busy_start", 1'b1, 1'b0, 24'd2, 3});
    rs_before = rs0;
    pulse_start0();
    repeat (6) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_start key", 32'(bus0.key), 32'd0);
    check("busy_start restarts", 32'(rs0 - rs_before), 32'd1);
    finish0(rs_before);

    // Reset in LAT during key 1's scan
    good_key0 = 24'd5; bad_msg0 = "ab#d";
    rs_before = rs0;
    pulse_start0();
    repeat (20) @(negedge clk);
    check("mid key", 32'(bus0.key), 32'd1);
    check("mid state LAT", 32'(u0.state), 32'(KS_LAT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid rst key", 32'(bus0.key), 32'd0);
    check("mid rst flags", {28'd0, bus0.restart, bus0.busy, bus0.found, bus0.failed}, 32'd0);
    check("mid rst dm_addr", 32'(bus0.dm_addr), 32'd0);
    check("mid rst state", 32'(u0.state), 32'(KS_IDLE));
    rs_before = rs0;
    repeat (20) @(negedge clk);
    check("mid rst no restart", 32'(rs0 - rs_before), 32'd0);
    check("restart width", 32'(rs_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
